fifo_rd_drain: RTL and testbench
================================

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

Parameters
REQ-001 SHALL have DATA_WIDTH, default 8: width of rdata and m_data.
REQ-002 SHALL have CNT_WIDTH, default 16: width of the pop counter.

Interface
REQ-003 SHALL use one clock and one reset: clock rclk, reset rrst_n, asynchronous, active-low.
REQ-004 rclk  input  1  read-domain clock; all state changes on its rising edge.
REQ-005 rrst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  drain enable; 0 inhibits new FIFO pops.
REQ-007 rempty  input  1  FIFO read-side empty flag.
REQ-008 rdata  input  DATA_WIDTH  FIFO read data, show-ahead: valid whenever rempty=0.
REQ-009 rinc  output  1  FIFO pop request; the FIFO pops at the rising edge where rinc=1.
REQ-010 m_data  output  DATA_WIDTH  downstream data, registered.
REQ-011 m_valid  output  1  downstream data valid, registered.
REQ-012 m_ready  input  1  downstream accept.
REQ-013 pop_cnt  output  CNT_WIDTH  count of FIFO pops since reset, registered.
REQ-014 idle  output  1  high when the buffer is empty and rempty=1, combinational.

Function
REQ-015 SHALL hold a 2-entry in-order buffer (head, tail) with occupancy state EMPTY, ONE or TWO.
REQ-016 SHALL drive rinc = en & ~rempty & (state != TWO), combinational; rinc SHALL never be 1 while rempty=1.
REQ-017 "push" = rinc at a rising edge: rdata is captured into the buffer at that edge.
REQ-018 "pop" = m_valid & m_ready at a rising edge: the head is consumed.
REQ-019 Latency: a word captured at edge N appears on m_data with m_valid=1 after edge N when the buffer was EMPTY.
REQ-020 EMPTY + push -> ONE, head=rdata; EMPTY with no push -> EMPTY.
REQ-021 ONE: push & pop -> ONE, head=rdata; push only -> TWO, tail=rdata; pop only -> EMPTY; neither -> ONE.
REQ-022 TWO: push is impossible per REQ-016; pop -> ONE, head=tail; no pop -> TWO.
REQ-023 SHALL sustain one word per cycle while rempty=0, en=1 and m_ready=1.
REQ-024 m_valid SHALL be 1 exactly in ONE and TWO; m_data SHALL always equal head.
REQ-025 m_data and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-026 Words SHALL leave in FIFO order with no loss or duplication.
REQ-027 pop_cnt SHALL increment by 1 on each push and wrap from 2^CNT_WIDTH-1 to 0.
REQ-028 en falling SHALL deassert rinc in the same cycle; buffered words SHALL still drain to the downstream.
REQ-029 m_ready with m_valid=0 SHALL have no effect.

Reset
REQ-030 While rrst_n=0: state=EMPTY, m_valid=0, m_data=0, pop_cnt=0, applied asynchronously.
REQ-031 rinc SHALL be 0 while rrst_n=0, regardless of en and rempty.
REQ-032 Reset asserted mid-operation SHALL discard buffered words; operation SHALL resume from EMPTY at the first rising rclk after rrst_n rises.

Verification
REQ-033 Reset with en=1, rempty=0 -> rinc=0, m_valid=0, pop_cnt=0 until release; after release, rinc=1 in the first cycle.
REQ-034 Stream A1,A2,A3 with m_ready=1 held, FIFO never empty -> m_data A1,A2,A3 on consecutive cycles, first one cycle after the first push; pop_cnt=3.
REQ-035 m_ready=0 with 5 words in the FIFO -> exactly 2 pushes, then rinc=0 and state TWO; m_ready=1 -> remaining 3 words follow in order, 1 per cycle.
REQ-036 en=0 mid-stream with the buffer holding 1 word -> rinc=0 the same cycle, that word still delivered, then m_valid=0 and idle=1 when rempty=1.
REQ-037 CNT_WIDTH=4, 17 pushes -> pop_cnt reads 15 then 0 then 1.
REQ-038 rrst_n=0 pulse between clock edges while in TWO -> m_valid=0 immediately, no stale words emitted after release.

Source files
------------

// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if
// Groups the FIFO read-side handshake and the downstream valid/ready bus
// of the read-drain block.
//   rempty  : FIFO read-side empty flag
//   rdata   : FIFO show-ahead read data (valid whenever rempty = 0)
//   rinc    : FIFO pop request
//   m_data  : downstream data
//   m_valid : downstream data valid
//   m_ready : downstream accept
// master = drain block, slave = FIFO plus downstream consumer.
interface fifo_rd_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_data, m_valid
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_data, m_valid
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
// Drains a show-ahead FIFO into a registered valid/ready stream through a
// 2-entry in-order skid buffer (head, tail), sustaining one word per cycle.
// Ports:
//   rclk    : read-domain clock, rising edge
//   rrst_n  : asynchronous active-low reset
//   en      : drain enable; 0 stops new FIFO pops, buffered words still drain
//   bus     : fifo_rd_drain_if.master (rempty/rdata/rinc, m_data/m_valid/m_ready)
//   pop_cnt : number of FIFO pops since reset, wraps
//   idle    : buffer empty and FIFO empty
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 en,
  fifo_rd_drain_if.master      bus,
  output logic [CNT_WIDTH-1:0] pop_cnt,
  output logic                 idle
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] head_p0;
  logic [DATA_WIDTH-1:0] tail_p0;
  logic                  push;
  logic                  pop;
  logic                  head_ld;
  logic                  head_from_tail;
  logic                  tail_ld;

  // Gating with rrst_n keeps rinc low for the whole reset, even though the
  // state register already reads EMPTY there.
  assign push        = rrst_n & en & ~bus.rempty & (state != TWO);
  assign pop         = bus.m_valid & bus.m_ready;
  assign bus.rinc    = push;
  assign bus.m_valid = (state != EMPTY);
  assign bus.m_data  = head_p0;
  assign idle        = (state == EMPTY) & bus.rempty;

  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_from_tail = 1'b0;
    tail_ld        = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          head_ld   = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_ld = 1'b1;
        end else if (push) begin
          state_nxt = TWO;
          tail_ld   = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // push cannot occur here: rinc is held low while the buffer is full.
        if (pop) begin
          state_nxt      = ONE;
          head_ld        = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // ---- stage p0: occupancy, head register and pop counter ----
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state   <= EMPTY;
      head_p0 <= '0;
      pop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (head_ld) begin
        head_p0 <= head_from_tail ? tail_p0 : bus.rdata;
      end
      if (push) begin
        pop_cnt <= pop_cnt + 1'b1;
      end
    end
  end

  // Tail is pure data and only meaningful in TWO, so it needs no reset.
  always_ff @(posedge rclk) begin
    if (tail_ld) begin
      tail_p0 <= bus.rdata;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain
// Bench for fifo_rd_drain (CNT_WIDTH = 4). A behavioural show-ahead FIFO
// feeds the DUT; every word loaded into it is queued as expected output and
// a monitor compares each downstream transfer against that queue, while the
// stimulus thread checks hand-computed values at fixed cycles.
module tb_fifo_rd_drain;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       en;
  logic [3:0] pop_cnt;
  logic       idle;

  fifo_rd_drain_if #(.DATA_WIDTH(8)) bus();

  fifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .en      (en),
    .bus     (bus),
    .pop_cnt (pop_cnt),
    .idle    (idle)
  );

  always #5 rclk = ~rclk;

  logic [7:0] mem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] exp_q [$];
  int         rst_cnt = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  assign bus.rempty = (rd_ptr == wr_ptr);
  assign bus.rdata  = mem[rd_ptr % 64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic load(input logic [7:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  task automatic fifo_loop();
    logic p;
    forever begin
      @(negedge rclk);
      p = bus.rinc;
      @(posedge rclk);
      #1;
      if (p) rd_ptr++;
    end
  endtask

  task automatic monitor_loop();
    logic       hold;
    logic [7:0] hold_d;
    int         seen;
    hold = 1'b0;
    hold_d = '0;
    seen = 0;
    forever begin
      @(negedge rclk);
      if (seen != rst_cnt) begin
        hold = 1'b0;
        seen = rst_cnt;
      end
      if (rrst_n) begin
        if (hold) check("hold_stable", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, hold_d});
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_word: got %0h, expected no transfer (t=%0t)", bus.m_data, $time);
          end else begin
            check("order", {24'd0, bus.m_data}, {24'd0, exp_q.pop_front()});
          end
        end
        hold   = bus.m_valid & ~bus.m_ready;
        hold_d = bus.m_data;
      end
    end
  endtask

  task automatic stimulus();
    logic [7:0] a_w [3];
    logic [7:0] b_w [5];
    int         t;
    a_w = '{8'hA1, 8'hA2, 8'hA3};
    b_w = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};

    // reset held with FIFO non-empty and en=1
    rrst_n = 1'b0;
    en = 1'b1;
    bus.m_ready = 1'b1;
    load(8'h11);
    repeat (2) @(negedge rclk);
    check("rst_rinc", bus.rinc, 0);
    check("rst_valid", bus.m_valid, 0);
    check("rst_data", bus.m_data, 0);
    check("rst_cnt", pop_cnt, 0);
    @(posedge rclk); #2;
    rrst_n = 1'b1;
    @(negedge rclk);
    check("rinc_first_cycle", bus.rinc, 1);
    @(negedge rclk);
    check("first_valid", bus.m_valid, 1);
    check("first_data", bus.m_data, 8'h11);
    @(negedge rclk);
    check("first_idle", idle, 1);
    check("first_cnt", pop_cnt, 1);

    // streaming A1..A3, one per cycle
    @(posedge rclk); #2;
    for (int i = 0; i < 3; i++) load(a_w[i]);
    @(negedge rclk);
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      check("stream_valid", bus.m_valid, 1);
      check("stream_data", bus.m_data, a_w[i]);
    end
    @(negedge rclk);
    check("stream_cnt", pop_cnt, 4);
    check("stream_done_valid", bus.m_valid, 0);

    // backpressure: two pushes fill the buffer, then release
    @(posedge rclk); #2;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(b_w[i]);
    repeat (3) @(negedge rclk);
    check("full_rinc", bus.rinc, 0);
    check("full_valid", bus.m_valid, 1);
    check("full_data", bus.m_data, 8'hB1);
    check("full_cnt", pop_cnt, 6);
    check("full_idle", idle, 0);
    @(negedge rclk);
    check("full_rinc_hold", bus.rinc, 0);
    @(posedge rclk); #2;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      check("bp_data", bus.m_data, b_w[i]);
    end
    @(negedge rclk);
    check("bp_cnt", pop_cnt, 9);
    check("bp_idle", idle, 1);

    // en drop with one word buffered
    @(posedge rclk); #2;
    load(8'hC1);
    load(8'hC2);
    load(8'hC3);
    @(negedge rclk);
    @(posedge rclk); #2;
    en = 1'b0;
    #1;
    check("en_rinc_same_cycle", bus.rinc, 0);
    @(negedge rclk);
    check("en_word_valid", bus.m_valid, 1);
    check("en_word_data", bus.m_data, 8'hC1);
    @(negedge rclk);
    check("en_drained_valid", bus.m_valid, 0);
    check("en_idle_fifo_busy", idle, 0);
    check("en_cnt", pop_cnt, 10);
    @(posedge rclk); #2;
    en = 1'b1;
    repeat (4) @(negedge rclk);
    check("en_idle", idle, 1);
    check("en_cnt_final", pop_cnt, 12);

    // asynchronous reset pulse while holding two words
    @(posedge rclk); #2;
    bus.m_ready = 1'b0;
    load(8'hD1);
    load(8'hD2);
    load(8'hD3);
    repeat (3) @(negedge rclk);
    check("two_valid", bus.m_valid, 1);
    check("two_rinc", bus.rinc, 0);
    @(posedge rclk); #2;
    rrst_n = 1'b0;
    rst_cnt++;
    #1;
    check("arst_valid", bus.m_valid, 0);
    check("arst_data", bus.m_data, 0);
    check("arst_cnt", pop_cnt, 0);
    check("arst_rinc", bus.rinc, 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    #1;
    rrst_n = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge rclk);
    check("arst_resume_rinc", bus.rinc, 1);
    @(negedge rclk);
    check("arst_resume_data", bus.m_data, 8'hD3);
    @(negedge rclk);
    check("arst_resume_cnt", pop_cnt, 1);
    check("arst_resume_idle", idle, 1);

    // 17 pushes on a 4-bit counter
    @(posedge rclk); #2;
    rrst_n = 1'b0;
    rst_cnt++;
    for (int i = 0; i < 17; i++) load(8'h40 + 8'(i));
    @(posedge rclk); #2;
    rrst_n = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge rclk);
      check("wrap_cnt", pop_cnt, k % 16);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge rclk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    @(negedge rclk);
    check("final_idle", idle, 1);
  endtask

  initial begin
    fork
      fifo_loop();
      monitor_loop();
      stimulus();
      begin
        #20000;
        n_chk++;
        $display("FAIL watchdog: stimulus still running at t=%0t, expected completion", $time);
      end
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
